// File: rtl/frame_buf_index_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : frame_buf_index_ctrl_if
// Purpose  : Event, handshake and index/address bundle of the frame buffer
//            index manager.
// Revision : 1.0 - initial release
// ============================================================================
interface frame_buf_index_ctrl_if #(
  parameter int IDX_BITS  = 3,
  parameter int ADDR_BITS = 24
);
  logic                 wr_frame_start;
  logic                 wr_frame_done;
  logic                 rd_frame_start;
  logic                 write_req;
  logic                 write_req_ack;
  logic [IDX_BITS-1:0]  write_addr_index;
  logic [ADDR_BITS-1:0] write_addr;
  logic [IDX_BITS-1:0]  read_addr_index;
  logic [ADDR_BITS-1:0] read_addr;
  logic                 rd_new;
  logic [15:0]          drop_cnt;
  logic [15:0]          repeat_cnt;

  modport master (
    output wr_frame_start, wr_frame_done, rd_frame_start, write_req_ack,
    input  write_req, write_addr_index, write_addr, read_addr_index,
           read_addr, rd_new, drop_cnt, repeat_cnt
  );

  modport slave (
    input  wr_frame_start, wr_frame_done, rd_frame_start, write_req_ack,
    output write_req, write_addr_index, write_addr, read_addr_index,
           read_addr, rd_new, drop_cnt, repeat_cnt
  );
endinterface
`default_nettype wire

// File: rtl/frame_buf_index_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : frame_buf_index_ctrl
// Purpose  : N-buffer frame ownership manager; writer never shares the
//            displayed buffer, reader always takes the newest completed frame.
// Options  : FRAME_BUF_STATS_EN builds the drop/repeat statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
module frame_buf_index_ctrl #(
  parameter int NUM_BUFS     = 4,
  parameter int IDX_BITS     = 3,
  parameter int ADDR_BITS    = 24,
  parameter int BASE_ADDR    = 0,
  parameter int FRAME_STRIDE = 2073600
) (
  input logic                   clk,
  input logic                   rst,
  frame_buf_index_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    BUF_FREE    = 2'd0,
    BUF_WRITING = 2'd1,
    BUF_READY   = 2'd2,
    BUF_READING = 2'd3
  } buf_state_e;

  function automatic logic [ADDR_BITS-1:0] addr_of(input int idx);
    logic [63:0] full;
    full = 64'(BASE_ADDR) + 64'(idx) * 64'(FRAME_STRIDE);
    return full[ADDR_BITS-1:0];
  endfunction

  localparam logic [ADDR_BITS-1:0] c_wr_addr_rst = addr_of(1);
  localparam logic [ADDR_BITS-1:0] c_rd_addr_rst = addr_of(0);

  buf_state_e           state_q [NUM_BUFS];
  buf_state_e           state_d [NUM_BUFS];
  logic [IDX_BITS-1:0]  wr_idx_q, wr_idx_d;
  logic [IDX_BITS-1:0]  rd_idx_q, rd_idx_d;
  logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
  logic                 write_req_q, write_req_d;
  logic                 rd_new_q, rd_new_d;
  logic [1:0]           drop_inc_d;
  logic                 repeat_inc_d;

  // Events are applied in the order done -> display start -> write start,
  // each one rescanning the buffer states left by the previous one.
  always_comb begin
    int wr_buf;
    int lat_buf;
    int pick;
    int cand;
    state_d      = state_q;
    wr_idx_d     = wr_idx_q;
    rd_idx_d     = rd_idx_q;
    write_req_d  = write_req_q;
    rd_new_d     = 1'b0;
    drop_inc_d   = 2'd0;
    repeat_inc_d = 1'b0;
    wr_buf       = -1;
    lat_buf      = -1;
    pick         = -1;
    cand         = 0;

    if (write_req_q && bus.write_req_ack) begin
      write_req_d = 1'b0;
    end

    if (bus.wr_frame_done) begin
      wr_buf  = -1;
      lat_buf = -1;
      for (int i = 0; i < NUM_BUFS; i++) begin
        if (state_d[i] == BUF_WRITING) wr_buf = i;
        if (state_d[i] == BUF_READY)   lat_buf = i;
      end
      if (wr_buf >= 0) begin
        if (lat_buf >= 0) drop_inc_d = drop_inc_d + 2'd1;
        for (int i = 0; i < NUM_BUFS; i++) begin
          if (i == lat_buf) state_d[i] = BUF_FREE;
          if (i == wr_buf)  state_d[i] = BUF_READY;
        end
      end
    end

    if (bus.rd_frame_start) begin
      lat_buf = -1;
      for (int i = 0; i < NUM_BUFS; i++) begin
        if (state_d[i] == BUF_READY) lat_buf = i;
      end
      if (lat_buf >= 0) begin
        for (int i = 0; i < NUM_BUFS; i++) begin
          if (i == int'(rd_idx_q)) state_d[i] = BUF_FREE;
          if (i == lat_buf)        state_d[i] = BUF_READING;
        end
        rd_idx_d = IDX_BITS'(lat_buf);
        rd_new_d = 1'b1;
      end else begin
        repeat_inc_d = 1'b1;
      end
    end

    if (bus.wr_frame_start) begin
      if (write_req_q) begin
        drop_inc_d = drop_inc_d + 2'd1;
      end else begin
        wr_buf  = -1;
        lat_buf = -1;
        for (int i = 0; i < NUM_BUFS; i++) begin
          if (state_d[i] == BUF_WRITING) wr_buf = i;
          if (state_d[i] == BUF_READY)   lat_buf = i;
        end
        if (wr_buf >= 0) begin
          drop_inc_d = drop_inc_d + 2'd1;
          for (int i = 0; i < NUM_BUFS; i++) begin
            if (i == wr_buf) state_d[i] = BUF_FREE;
          end
        end
        // Walk the ring backwards so the last hit is the nearest one upward.
        for (int k = NUM_BUFS; k >= 1; k--) begin
          cand = (int'(wr_idx_q) + k) % NUM_BUFS;
          if (state_d[cand] == BUF_FREE) pick = cand;
        end
        if (pick < 0 && lat_buf >= 0) begin
          pick       = lat_buf;
          drop_inc_d = drop_inc_d + 2'd1;
        end
        if (pick >= 0) begin
          for (int i = 0; i < NUM_BUFS; i++) begin
            if (i == pick) state_d[i] = BUF_WRITING;
          end
          wr_idx_d    = IDX_BITS'(pick);
          write_req_d = 1'b1;
        end
      end
    end

    wr_addr_d = addr_of(int'(wr_idx_d));
    rd_addr_d = addr_of(int'(rd_idx_d));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BUFS; i++) begin
        state_q[i] <= (i == 0) ? BUF_READING : ((i == 1) ? BUF_WRITING : BUF_FREE);
      end
      wr_idx_q    <= IDX_BITS'(1);
      rd_idx_q    <= '0;
      wr_addr_q   <= c_wr_addr_rst;
      rd_addr_q   <= c_rd_addr_rst;
      write_req_q <= 1'b0;
      rd_new_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      wr_addr_q   <= wr_addr_d;
      rd_addr_q   <= rd_addr_d;
      write_req_q <= write_req_d;
      rd_new_q    <= rd_new_d;
    end
  end

  assign bus.write_req        = write_req_q;
  assign bus.write_addr_index = wr_idx_q;
  assign bus.write_addr       = wr_addr_q;
  assign bus.read_addr_index  = rd_idx_q;
  assign bus.read_addr        = rd_addr_q;
  assign bus.rd_new           = rd_new_q;

`ifdef FRAME_BUF_STATS_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [15:0] repeat_cnt_q, repeat_cnt_d;
  logic [16:0] drop_sum;

  always_comb begin
    drop_sum     = {1'b0, drop_cnt_q} + 17'(drop_inc_d);
    drop_cnt_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    repeat_cnt_d = (repeat_cnt_q == 16'hFFFF) ? repeat_cnt_q
                                              : repeat_cnt_q + 16'(repeat_inc_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q   <= 16'd0;
      repeat_cnt_q <= 16'd0;
    end else begin
      drop_cnt_q   <= drop_cnt_d;
      repeat_cnt_q <= repeat_cnt_d;
    end
  end

  assign bus.drop_cnt   = drop_cnt_q;
  assign bus.repeat_cnt = repeat_cnt_q;
`else
  logic unused_stats;
  assign unused_stats   = ^{drop_inc_d, repeat_inc_d};
  assign bus.drop_cnt   = 16'd0;
  assign bus.repeat_cnt = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_frame_buf_index_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_buf_index_ctrl
// Purpose  : Scoreboard bench for a 4-buffer and a 2-buffer instance driven
//            with the same directed and random event stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_buf_index_ctrl;
  localparam int       ADDR_BITS = 24;
  localparam int       BASE      = 0;
  localparam int       STRIDE    = 2073600;

  typedef struct {
    int rd;
    int wr;
    int lat;
    int ptr;
    bit req;
    bit rd_new;
    int drop;
    int rep;
  } model_t;

  typedef struct {
    longint widx;
    longint waddr;
    longint ridx;
    longint raddr;
    longint req;
    longint rd_new;
    longint drop;
    longint rep;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  int     n_checks = 0;
  int     n_fail = 0;
  model_t m4;
  model_t m2;
  exp_t   q4[$];
  exp_t   q2[$];

  always #5 clk = ~clk;

  frame_buf_index_ctrl_if #(.IDX_BITS(3), .ADDR_BITS(ADDR_BITS)) bus4 ();
  frame_buf_index_ctrl_if #(.IDX_BITS(1), .ADDR_BITS(ADDR_BITS)) bus2 ();

  frame_buf_index_ctrl #(
    .NUM_BUFS(4), .IDX_BITS(3), .ADDR_BITS(ADDR_BITS),
    .BASE_ADDR(BASE), .FRAME_STRIDE(STRIDE)
  ) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  frame_buf_index_ctrl #(
    .NUM_BUFS(2), .IDX_BITS(1), .ADDR_BITS(ADDR_BITS),
    .BASE_ADDR(BASE), .FRAME_STRIDE(STRIDE)
  ) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  function automatic longint addr(input int i);
    return (longint'(BASE) + longint'(i) * longint'(STRIDE)) % (longint'(1) << ADDR_BITS);
  endfunction

  function automatic model_t model_reset();
    model_t m;
    m.rd = 0; m.wr = 1; m.lat = -1; m.ptr = 1;
    m.req = 1'b0; m.rd_new = 1'b0; m.drop = 0; m.rep = 0;
    return m;
  endfunction

  // Buffers are tracked by role (reader, writer, latest); anything else is free.
  function automatic model_t model_step(input model_t mi, input int n,
                                        input bit done, input bit rd,
                                        input bit start, input bit ack);
    model_t m;
    bit     req_was;
    int     pick;
    int     c;
    m       = mi;
    req_was = m.req;
    m.rd_new = 1'b0;
    if (m.req && ack) m.req = 1'b0;
    if (done && m.wr >= 0) begin
      if (m.lat >= 0) m.drop = sat(m.drop + 1);
      m.lat = m.wr;
      m.wr  = -1;
    end
    if (rd) begin
      if (m.lat >= 0) begin
        m.rd = m.lat; m.lat = -1; m.rd_new = 1'b1;
      end else begin
        m.rep = sat(m.rep + 1);
      end
    end
    if (start) begin
      if (req_was) begin
        m.drop = sat(m.drop + 1);
      end else begin
        if (m.wr >= 0) begin
          m.drop = sat(m.drop + 1);
          m.wr   = -1;
        end
        pick = -1;
        for (int k = 1; k <= n && pick < 0; k++) begin
          c = (m.ptr + k) % n;
          if (c != m.rd && c != m.lat) pick = c;
        end
        if (pick < 0) begin
          pick   = m.lat;
          m.lat  = -1;
          m.drop = sat(m.drop + 1);
        end
        m.wr = pick; m.ptr = pick; m.req = 1'b1;
      end
    end
    return m;
  endfunction

  function automatic exp_t to_exp(input model_t m);
    exp_t e;
    e.widx   = longint'(m.ptr);
    e.waddr  = addr(m.ptr);
    e.ridx   = longint'(m.rd);
    e.raddr  = addr(m.rd);
    e.req    = longint'(m.req);
    e.rd_new = longint'(m.rd_new);
`ifdef FRAME_BUF_STATS_EN
    e.drop   = longint'(m.drop);
    e.rep    = longint'(m.rep);
`else
    e.drop   = 0;
    e.rep    = 0;
`endif
    return e;
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive(input bit d, input bit r, input bit s, input bit a, input bit rs);
    @(negedge clk);
    rst = rs;
    bus4.wr_frame_done = d; bus4.rd_frame_start = r;
    bus4.wr_frame_start = s; bus4.write_req_ack = a;
    bus2.wr_frame_done = d; bus2.rd_frame_start = r;
    bus2.wr_frame_start = s; bus2.write_req_ack = a;
    if (rs) begin
      m4 = model_reset();
      m2 = model_reset();
      #1;
      check("async_rst_write_req", longint'(bus4.write_req), 0);
      check("async_rst_write_index", longint'(bus4.write_addr_index), 1);
      check("async_rst_write_addr", longint'(bus4.write_addr), addr(1));
      check("async_rst_read_index", longint'(bus4.read_addr_index), 0);
      check("async_rst_n2_write_req", longint'(bus2.write_req), 0);
    end else begin
      m4 = model_step(m4, 4, d, r, s, a);
      m2 = model_step(m2, 2, d, r, s, a);
    end
    q4.push_back(to_exp(m4));
    q2.push_back(to_exp(m2));
  endtask

  // Monitor: one expected snapshot per clock for each instance.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q4.size() > 0) begin
        e = q4.pop_front();
        check("n4_write_addr_index", longint'(bus4.write_addr_index), e.widx);
        check("n4_write_addr", longint'(bus4.write_addr), e.waddr);
        check("n4_read_addr_index", longint'(bus4.read_addr_index), e.ridx);
        check("n4_read_addr", longint'(bus4.read_addr), e.raddr);
        check("n4_write_req", longint'(bus4.write_req), e.req);
        check("n4_rd_new", longint'(bus4.rd_new), e.rd_new);
        check("n4_drop_cnt", longint'(bus4.drop_cnt), e.drop);
        check("n4_repeat_cnt", longint'(bus4.repeat_cnt), e.rep);
      end
      if (q2.size() > 0) begin
        e = q2.pop_front();
        check("n2_write_addr_index", longint'(bus2.write_addr_index), e.widx);
        check("n2_write_addr", longint'(bus2.write_addr), e.waddr);
        check("n2_read_addr_index", longint'(bus2.read_addr_index), e.ridx);
        check("n2_read_addr", longint'(bus2.read_addr), e.raddr);
        check("n2_write_req", longint'(bus2.write_req), e.req);
        check("n2_rd_new", longint'(bus2.rd_new), e.rd_new);
        check("n2_drop_cnt", longint'(bus2.drop_cnt), e.drop);
        check("n2_repeat_cnt", longint'(bus2.repeat_cnt), e.rep);
      end
    end
  end

  initial begin : driver
    bit d, r, s, a, rs;
    bus4.wr_frame_done = 1'b0; bus4.rd_frame_start = 1'b0;
    bus4.wr_frame_start = 1'b0; bus4.write_req_ack = 1'b0;
    bus2.wr_frame_done = 1'b0; bus2.rd_frame_start = 1'b0;
    bus2.wr_frame_start = 1'b0; bus2.write_req_ack = 1'b0;
    m4 = model_reset();
    m2 = model_reset();

    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    // First write: new index, then ack held three cycles.
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    // Completed frame reaches the display.
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    // Display restarts with nothing new.
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    // Two completions without a display start.
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    // Done and display start in the same cycle.
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0);
    drive(1, 1, 0, 0, 0);
    // Start while write_req is still high, then all three events together.
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0);
    drive(1, 1, 1, 0, 0);
    drive(0, 0, 0, 1, 0);
    // Reset while write_req is high.
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    // From reset: complete then restart the writer (forces re-use with two buffers).
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 1, 0, 0, 0);

    for (int i = 0; i < 4000; i++) begin
      d  = ($urandom_range(0, 5) == 0);
      r  = ($urandom_range(0, 4) == 0);
      s  = ($urandom_range(0, 5) == 0);
      a  = ($urandom_range(0, 2) == 0);
      rs = ($urandom_range(0, 799) == 0);
      drive(d, r, s, a, rs);
    end
    drive(0, 0, 0, 0, 0);

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", longint'(q4.size() + q2.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
